bullet_pool: RTL and testbench

//  Multi-slot projectile engine for one shooter/target pair: N bullets in flight, per-frame motion,
//  off-screen retire, hitbox test vs target (shield/squat aware), saturating target HP.

---
 rtl/bullet_pool_pkg.sv | 30 +++
 rtl/bullet_hit_check.sv | 29 ++
 rtl/bullet_pool.sv | 180 ++++++++++++++++++
 tb/tb_bullet_pool.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pool_pkg.sv
// Shared constants and types for the bullet pool: default sizes, slot record and engine states.
package bullet_pool_pkg;

    localparam int X_W             = 11;
    localparam int BULLET_SLOTS    = 4;
    localparam int BULLET_STEP_X   = 12;
    localparam int BULLET_H_MAX    = 1279;
    localparam int BULLET_COOLDOWN = 8;
    localparam int BULLET_HP_W     = 3;

    localparam int TGT_W    = 64;
    localparam int TGT_H    = 96;
    localparam int TGT_H_SQ = 48;
    localparam int BUL_W    = 16;
    localparam int BUL_H    = 8;

    typedef struct packed {
        logic           valid;
        logic           dir;
        logic [X_W-1:0] x;
        logic [X_W-1:0] y;
    } bullet_t;

    typedef enum logic [1:0] {
        BP_IDLE   = 2'd0,
        BP_UPDATE = 2'd1,
        BP_SPAWN  = 2'd2
    } bp_state_t;

endpackage

// File: rtl/bullet_hit_check.sv
// Combinational rectangle overlap of one bullet box against the target box.
// Touching edges count as a hit; squatting shrinks the box from the top.
module bullet_hit_check
    import bullet_pool_pkg::*;
(
    input  logic [X_W-1:0] bul_x,
    input  logic [X_W-1:0] bul_y,
    input  logic [X_W-1:0] tgt_x,
    input  logic [X_W-1:0] tgt_y,
    input  logic           squat,
    output logic           hit
);

    localparam int W = X_W + 2;

    logic [W-1:0] bx, by, tx, ty, th;

    // Two spare bits keep every edge sum exact for any coordinate pair.
    always_comb begin
        bx  = W'(bul_x);
        by  = W'(bul_y);
        tx  = W'(tgt_x);
        ty  = W'(tgt_y) + (squat ? W'(TGT_H - TGT_H_SQ) : '0);
        th  = squat ? W'(TGT_H_SQ) : W'(TGT_H);
        hit = (bx <= tx + W'(TGT_W)) && (tx <= bx + W'(BUL_W)) &&
              (by <= ty + th)        && (ty <= by + W'(BUL_H));
    end

endmodule

// File: rtl/bullet_pool.sv
// Multi-slot projectile engine: per-frame motion, off-screen retire, target hit test and HP.
// One slot is updated per cycle after a frame tick, followed by one spawn opportunity.
module bullet_pool
    import bullet_pool_pkg::*;
#(
    parameter int NUM_SLOTS = BULLET_SLOTS,
    parameter int STEP      = BULLET_STEP_X,
    parameter int H_MAX     = BULLET_H_MAX,
    parameter int COOLDOWN  = BULLET_COOLDOWN,
    parameter int HP_WIDTH  = BULLET_HP_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_frame_tick,
    input  logic                     i_fire,
    input  logic                     i_dir,
    input  logic [X_W-1:0]           i_shooter_x,
    input  logic [X_W-1:0]           i_shooter_y,
    input  logic [X_W-1:0]           i_target_x,
    input  logic [X_W-1:0]           i_target_y,
    input  logic                     i_target_shield,
    input  logic                     i_target_squat,
    output logic [NUM_SLOTS-1:0]     o_valid,
    output logic [NUM_SLOTS*X_W-1:0] o_x,
    output logic [NUM_SLOTS*X_W-1:0] o_y,
    output logic                     o_fire_ack,
    output logic                     o_hit,
    output logic [HP_WIDTH-1:0]      o_target_hp,
    output logic                     o_dead,
    output logic [1:0]               o_state
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CD_W  = $clog2(COOLDOWN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    bullet_t          slot_q [NUM_SLOTS];
    bullet_t          slot_d [NUM_SLOTS];
    bp_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, free_idx;
    logic [HP_WIDTH-1:0] hp_q, hp_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic             fire_pend_q, fire_pend_d;
    logic             tick_pend_q, tick_pend_d;
    logic             hit_q, hit_d, ack_q, ack_d;
    logic             free_found;

    bullet_t          cur;
    logic [X_W:0]     x_fwd, x_back;
    logic [X_W-1:0]   x_next;
    logic             off_screen, tgt_hit;

    assign cur = slot_q[idx_q];

    // The extra top bit carries the borrow (leftward) or the overshoot (rightward).
    always_comb begin
        x_fwd  = {1'b0, cur.x} + (X_W+1)'(STEP);
        x_back = {1'b0, cur.x} - (X_W+1)'(STEP);
        if (cur.dir) begin
            x_next     = x_back[X_W-1:0];
            off_screen = x_back[X_W];
        end else begin
            x_next     = x_fwd[X_W-1:0];
            off_screen = x_fwd > (X_W+1)'(H_MAX);
        end
    end

    bullet_hit_check u_hit (
        .bul_x (x_next),
        .bul_y (cur.y),
        .tgt_x (i_target_x),
        .tgt_y (i_target_y),
        .squat (i_target_squat),
        .hit   (tgt_hit)
    );

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        slot_d      = slot_q;
        state_d     = state_q;
        idx_d       = idx_q;
        hp_d        = hp_q;
        cd_d        = cd_q;
        fire_pend_d = fire_pend_q | (i_fire && (cd_q == '0));
        tick_pend_d = tick_pend_q;
        hit_d       = 1'b0;
        ack_d       = 1'b0;

        case (state_q)
            BP_IDLE: begin
                if (i_frame_tick || tick_pend_q) begin
                    state_d     = BP_UPDATE;
                    idx_d       = '0;
                    tick_pend_d = 1'b0;
                end
            end
            BP_UPDATE: begin
                if (i_frame_tick) tick_pend_d = 1'b1;
                if (cur.valid) begin
                    if (off_screen) begin
                        slot_d[idx_q] = '0;
                    end else if (tgt_hit) begin
                        slot_d[idx_q] = '0;
                        if (!i_target_shield && (hp_q != '0)) begin
                            hp_d  = hp_q - HP_WIDTH'(1);
                            hit_d = 1'b1;
                        end
                    end else begin
                        slot_d[idx_q].x = x_next;
                    end
                end
                if (idx_q == LAST_IDX) state_d = BP_SPAWN;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            BP_SPAWN: begin
                if (i_frame_tick) tick_pend_d = 1'b1;
                state_d = BP_IDLE;
                if (fire_pend_q && (cd_q == '0) && free_found) begin
                    slot_d[free_idx] = '{valid: 1'b1, dir: i_dir, x: i_shooter_x, y: i_shooter_y};
                    ack_d       = 1'b1;
                    cd_d        = CD_W'(COOLDOWN);
                    fire_pend_d = 1'b0;
                end else if (cd_q != '0) begin
                    cd_d = cd_q - CD_W'(1);
                end
            end
            default: state_d = BP_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
            state_q     <= BP_IDLE;
            idx_q       <= '0;
            hp_q        <= '1;
            cd_q        <= '0;
            fire_pend_q <= 1'b0;
            tick_pend_q <= 1'b0;
            hit_q       <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            hp_q        <= hp_d;
            cd_q        <= cd_d;
            fire_pend_q <= fire_pend_d;
            tick_pend_q <= tick_pend_d;
            hit_q       <= hit_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            o_valid[i]            = slot_q[i].valid;
            o_x[i*X_W +: X_W]     = slot_q[i].x;
            o_y[i*X_W +: X_W]     = slot_q[i].y;
        end
    end

    assign o_fire_ack  = ack_q;
    assign o_hit       = hit_q;
    assign o_target_hp = hp_q;
    assign o_dead      = (hp_q == '0);
    assign o_state     = state_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: single-bullet trajectory table plus held-fire, kill, clear and tick-latch sequences.
module tb_bullet_pool;
    import bullet_pool_pkg::*;

    localparam int N  = 4;
    localparam int XW = 11;
    localparam int HW = 3;

    logic clk = 1'b0;
    logic rst, clear, tick, fire, dir, shield, squat;
    logic [XW-1:0] sx, sy, tx, ty;
    logic [N-1:0]    valid;
    logic [N*XW-1:0] ox, oy;
    logic            fire_ack, hit, dead;
    logic [HW-1:0]   hp;
    logic [1:0]      state;

    int vec_count  = 0;
    int fail_count = 0;
    int ack_total  = 0;
    int hit_total  = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic          dir;
        logic [XW-1:0] sx, sy, tx, ty;
        logic          shield, squat;
        int            ticks;
        logic          exp_valid;
        logic [XW-1:0] exp_x;
        logic [HW-1:0] exp_hp;
        int            exp_hits;
    } vec_t;

    vec_t vecs[20];

    bullet_pool dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_frame_tick(tick),
        .i_fire(fire), .i_dir(dir), .i_shooter_x(sx), .i_shooter_y(sy),
        .i_target_x(tx), .i_target_y(ty), .i_target_shield(shield),
        .i_target_squat(squat), .o_valid(valid), .o_x(ox), .o_y(oy),
        .o_fire_ack(fire_ack), .o_hit(hit), .o_target_hp(hp), .o_dead(dead),
        .o_state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fire_ack) ack_total++;
        if (hit) hit_total++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        vec_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic use_clear);
        if (use_clear) clear = 1'b1; else rst = 1'b1;
        step(1);
        clear = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 40;
        while (state !== 2'd0 && budget > 0) begin
            step(1);
            budget--;
        end
        vec_count++;
        if (budget == 0) begin
            fail_count++;
            $display("FAIL frame_timeout: state %0d never returned to idle", state);
        end
    endtask

    task automatic frame();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        wait_idle();
        step(1);
    endtask

    task automatic fire_pulse();
        fire = 1'b1;
        step(1);
        fire = 1'b0;
    endtask

    initial begin
        int a0, h0, exp_frame;
        logic [15:0] e;

        rst = 1'b1; clear = 1'b0; tick = 1'b0; fire = 1'b0; dir = 1'b0;
        shield = 1'b0; squat = 1'b0;
        sx = 11'd100; sy = 11'd100; tx = 11'd2000; ty = 11'd2000;

        //                 dir  sx    sy   tx    ty   sh  sq  tk  v   x    hp  hits
        vecs[0]  = '{1'b0, 100,  100, 2000, 2000, 0, 0, 3,  1, 136,  7, 0};
        vecs[1]  = '{1'b0, 1270, 100, 2000, 2000, 0, 0, 1,  0, 0,    7, 0};
        vecs[2]  = '{1'b1, 5,    100, 2000, 2000, 0, 0, 1,  0, 0,    7, 0};
        vecs[3]  = '{1'b1, 500,  100, 2000, 2000, 0, 0, 4,  1, 452,  7, 0};
        vecs[4]  = '{1'b0, 1267, 100, 2000, 2000, 0, 0, 1,  1, 1279, 7, 0};
        vecs[5]  = '{1'b0, 1268, 100, 2000, 2000, 0, 0, 1,  0, 0,    7, 0};
        vecs[6]  = '{1'b1, 12,   100, 2000, 2000, 0, 0, 1,  1, 0,    7, 0};
        vecs[7]  = '{1'b1, 11,   100, 2000, 2000, 0, 0, 1,  0, 0,    7, 0};
        vecs[8]  = '{1'b0, 100,  100, 200,  100,  0, 0, 6,  1, 172,  7, 0};
        vecs[9]  = '{1'b0, 100,  100, 200,  100,  0, 0, 7,  0, 0,    6, 1};
        vecs[10] = '{1'b0, 100,  100, 200,  100,  1, 0, 7,  0, 0,    7, 0};
        vecs[11] = '{1'b0, 100,  110, 200,  100,  0, 1, 10, 1, 220,  7, 0};
        vecs[12] = '{1'b0, 100,  110, 200,  100,  0, 0, 7,  0, 0,    6, 1};
        vecs[13] = '{1'b1, 300,  100, 200,  100,  0, 0, 2,  1, 276,  7, 0};
        vecs[14] = '{1'b1, 300,  100, 200,  100,  0, 0, 3,  0, 0,    6, 1};
        vecs[15] = '{1'b0, 100,  196, 200,  100,  0, 0, 7,  0, 0,    6, 1};
        vecs[16] = '{1'b0, 100,  197, 200,  100,  0, 0, 7,  1, 184,  7, 0};
        vecs[17] = '{1'b0, 100,  91,  200,  100,  0, 0, 7,  1, 184,  7, 0};
        vecs[18] = '{1'b0, 100,  92,  200,  100,  0, 0, 7,  0, 0,    6, 1};
        vecs[19] = '{1'b0, 100,  196, 200,  100,  0, 1, 7,  0, 0,    6, 1};

        @(negedge clk);
        step(2);
        rst = 1'b0;

        // Reset state, then idle frames with no fire request.
        check("reset_state", state, 0);
        check("reset_x", ox, 0);
        a0 = ack_total; h0 = hit_total;
        repeat (3) frame();
        check("idle_valid", valid, 0);
        check("idle_hp", hp, 7);
        check("idle_dead", dead, 0);
        check("idle_acks", ack_total - a0, 0);
        check("idle_hits", hit_total - h0, 0);

        // Single-bullet trajectory table.
        for (int i = 0; i < 20; i++) begin
            do_reset(logic'(i % 2));
            dir = vecs[i].dir; sx = vecs[i].sx; sy = vecs[i].sy;
            tx = vecs[i].tx; ty = vecs[i].ty;
            shield = vecs[i].shield; squat = vecs[i].squat;
            exp_q.push_back({1'b0, vecs[i].exp_valid, vecs[i].exp_x, vecs[i].exp_hp});
            a0 = ack_total;
            fire_pulse();
            frame();
            check($sformatf("vec%0d_ack", i), ack_total - a0, 1);
            h0 = hit_total;
            repeat (vecs[i].ticks) frame();
            e = exp_q.pop_front();
            check($sformatf("vec%0d_valid_x_hp", i), {1'b0, valid[0], ox[XW-1:0], hp}, e);
            check($sformatf("vec%0d_hits", i), hit_total - h0, vecs[i].exp_hits);
        end

        // Fire held: cooldown spacing, then the fifth request waits for a retiring slot.
        do_reset(1'b0);
        dir = 1'b0; sx = 11'd800; sy = 11'd100; tx = 11'd2000; ty = 11'd2000;
        shield = 1'b0; squat = 1'b0;
        exp_q.push_back(16'd1);  exp_q.push_back(16'd10); exp_q.push_back(16'd19);
        exp_q.push_back(16'd28); exp_q.push_back(16'd41);
        fire = 1'b1;
        for (int f = 1; f <= 45; f++) begin
            a0 = ack_total;
            frame();
            if (ack_total != a0) begin
                exp_frame = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
                check("held_fire_ack_frame", f, exp_frame);
            end
            if (f == 37) check("held_fire_full", valid, 4'hf);
        end
        fire = 1'b0;
        check("held_fire_pending_left", exp_q.size(), 0);

        // Repeated damaging hits down to zero, then one hit while dead.
        do_reset(1'b1);
        dir = 1'b0; sx = 11'd180; sy = 11'd100; tx = 11'd200; ty = 11'd100;
        for (int s = 0; s < 8; s++) begin
            exp_q.push_back(16'((s < 7) ? 6 - s : 0));
            h0 = hit_total;
            fire_pulse();
            frame();
            frame();
            repeat (8) frame();
            e = exp_q.pop_front();
            check($sformatf("kill_shot%0d_hp", s), hp, e);
            check($sformatf("kill_shot%0d_hits", s), hit_total - h0, (s < 7) ? 1 : 0);
        end
        check("kill_dead", dead, 1);
        check("kill_valid", valid, 0);

        // Clear asserted while the frame update is in progress.
        fire_pulse();
        frame();
        check("clear_pre_valid", valid, 1);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        check("clear_mid_update_state", state, 1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_valid", valid, 0);
        check("clear_hp", hp, 7);
        check("clear_dead", dead, 0);
        check("clear_state", state, 0);
        check("clear_x", ox, 0);

        // Ticks during a frame: one is latched, further ones are dropped.
        do_reset(1'b0);
        dir = 1'b0; sx = 11'd100; sy = 11'd100; tx = 11'd2000; ty = 11'd2000;
        fire_pulse();
        frame();
        tick = 1'b1;
        step(3);
        tick = 1'b0;
        step(30);
        check("tick_latch_x", ox[XW-1:0], 124);
        check("tick_latch_valid", valid[0], 1);
        check("tick_latch_state", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
